uart_echo_engine: RTL and testbench



---
 rtl/uart_echo_pkg.sv | 29 ++
 rtl/uart_line_buf.sv | 27 ++
 rtl/uart_echo_engine.sv | 170 +++++++++++++++++
 tb/tb_uart_echo_engine.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_pkg.sv
// Shared encodings and helpers for the UART echo engine.
package uart_echo_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_CASE = 2'd1,
        MODE_LINE = 2'd2,
        MODE_REV  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PASS    = 2'd1,
        COLLECT = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    localparam logic [7:0] DEFAULT_TERM = 8'h0D;
    localparam int         CASE_BIT     = 5;
    localparam logic [7:0] CASE_MASK    = 8'(1) << CASE_BIT;

    function automatic logic [7:0] case_toggle(input logic [7:0] c);
        logic alpha;
        alpha = ((c >= 8'h41) && (c <= 8'h5A)) ||
                ((c >= 8'h61) && (c <= 8'h7A));
        return alpha ? (c ^ CASE_MASK) : c;
    endfunction

endpackage

// File: rtl/uart_line_buf.sv
// Line storage: DEPTH x DATA_W registers, one write port, async read.
module uart_line_buf
    import uart_echo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int IW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/uart_echo_engine.sv
// RX-FIFO to TX-FIFO echo engine: pass, case-toggle, line, line-reverse.
// Define ECHO_STATS_EN to add rx_count/tx_count pulse counters.
module uart_echo_engine
    import uart_echo_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                DEPTH  = 16,
    parameter logic [DATA_W-1:0] TERM   = DATA_W'(DEFAULT_TERM)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] r_data,
    input  logic              rx_empty,
    output logic              rd_uart,
    output logic [DATA_W-1:0] t_data,
    output logic              wr_uart,
    input  logic              tx_full,
    output logic              busy,
    output logic              line_ovf
`ifdef ECHO_STATS_EN
    ,
    output logic [15:0]       rx_count,
    output logic [15:0]       tx_count
`endif
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    state_e            state;
    mode_e             active_mode;
    logic [CW-1:0]     count;
    logic [CW-1:0]     n;
    logic [CW-1:0]     body_len;
    logic              term_seen;
    logic              pulse_busy;
    logic              pass_ok;
    logic              pop_ok;
    logic              push_ok;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] pass_data;

    assign pulse_busy = rd_uart | wr_uart;
    assign pass_ok = (state == PASS) && !pulse_busy && en &&
                     !rx_empty && !tx_full;
    assign pop_ok  = (state == COLLECT) && !pulse_busy && en && !rx_empty;
    assign push_ok = (state == DRAIN) && !pulse_busy && !tx_full;
    assign wr_idx  = IW'(count);

    // Reverse mode walks the body backwards; a trailing TERM goes last.
    always_comb begin
        body_len = term_seen ? (count - CW'(1)) : count;
        rd_idx   = IW'(n);
        if ((active_mode == MODE_REV) && (n < body_len)) begin
            rd_idx = IW'(body_len - n - CW'(1));
        end
    end

    if (DATA_W == 8) begin : g_case
        always_comb begin
            pass_data = r_data;
            if (active_mode == MODE_CASE) begin
                pass_data = case_toggle(r_data);
            end
        end
    end else begin : g_nocase
        assign pass_data = r_data;
    end

    uart_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IW     (IW)
    ) u_buf (
        .clock   (clock),
        .wr_en   (pop_ok),
        .wr_idx  (wr_idx),
        .wr_data (r_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            active_mode <= MODE_PASS;
            rd_uart     <= 1'b0;
            wr_uart     <= 1'b0;
            t_data      <= '0;
            busy        <= 1'b0;
            line_ovf    <= 1'b0;
            count       <= '0;
            n           <= '0;
            term_seen   <= 1'b0;
        end else begin
            rd_uart <= 1'b0;
            wr_uart <= 1'b0;
            unique case (state)
                IDLE: begin
                    active_mode <= mode_e'(mode);
                    busy        <= 1'b0;
                    count       <= '0;
                    n           <= '0;
                    term_seen   <= 1'b0;
                    state       <= (mode < 2'd2) ? PASS : COLLECT;
                end
                PASS: begin
                    if (pass_ok) begin
                        rd_uart <= 1'b1;
                        wr_uart <= 1'b1;
                        t_data  <= pass_data;
                    end else if (!pulse_busy) begin
                        state <= IDLE;
                    end
                end
                COLLECT: begin
                    if (pop_ok) begin
                        rd_uart <= 1'b1;
                        busy    <= 1'b1;
                        count   <= count + CW'(1);
                        if (r_data == TERM) begin
                            term_seen <= 1'b1;
                            state     <= DRAIN;
                        end else if (count == CW'(DEPTH - 1)) begin
                            line_ovf <= 1'b1;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (push_ok) begin
                        wr_uart <= 1'b1;
                        t_data  <= rd_data;
                        if (n == count - CW'(1)) begin
                            n         <= '0;
                            count     <= '0;
                            term_seen <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            n <= n + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ECHO_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            if (rd_uart) begin
                rx_count <= rx_count + 16'd1;
            end
            if (wr_uart) begin
                tx_count <= tx_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_echo_engine.sv
// Bench for uart_echo_engine: RX FIFO model, TX scoreboard, vector table.
module tb_uart_echo_engine;

    localparam int         DATA_W = 8;
    localparam int         DEPTH  = 16;
    localparam logic [7:0] TERM   = 8'h0D;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] r_data = 8'h00;
    logic       rx_empty = 1'b1;
    logic       tx_full = 1'b0;
    logic       rd_uart;
    logic       wr_uart;
    logic [7:0] t_data;
    logic       busy;
    logic       line_ovf;
`ifdef ECHO_STATS_EN
    logic [15:0] rx_count;
    logic [15:0] tx_count;
`endif

    always #5 clock = ~clock;

    uart_echo_engine #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TERM   (TERM)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .en       (en),
        .mode     (mode),
        .r_data   (r_data),
        .rx_empty (rx_empty),
        .rd_uart  (rd_uart),
        .t_data   (t_data),
        .wr_uart  (wr_uart),
        .tx_full  (tx_full),
        .busy     (busy),
        .line_ovf (line_ovf)
`ifdef ECHO_STATS_EN
        ,
        .rx_count (rx_count),
        .tx_count (tx_count)
`endif
    );

    logic [7:0] rxq [$];
    logic [7:0] sbq [$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  pops = 0;
    int  wrs = 0;
    int  last_wr_cyc = -100;
    int  wr_gap = 0;
    bit  hold_wr = 1'b0;
    bit  release_on_term = 1'b0;
    bit  pass_sec = 1'b0;
    logic ovf_at [64];
    logic busy_at [64];

    // RX FIFO model, TX scoreboard and pulse monitor, all at negedge.
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clock);
            cyc++;
            if (rd_uart) begin
                checks++;
                if (rxq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rd: rd_uart=1 with RX FIFO empty, required no pop");
                end else begin
                    if (release_on_term && rxq[0] == TERM) hold_wr = 1'b0;
                    void'(rxq.pop_front());
                    pops++;
                    if (pops < 64) ovf_at[pops] = line_ovf;
                end
            end
            if (wr_uart) begin
                checks++;
                wrs++;
                if (wrs < 64) busy_at[wrs] = busy;
                wr_gap = cyc - last_wr_cyc;
                last_wr_cyc = cyc;
                if (hold_wr) begin
                    errors++;
                    $display("FAIL early_wr: wr_uart=1 t_data=%h, required no push yet", t_data);
                end else if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wr: t_data=%h, required no push", t_data);
                end else begin
                    exp = sbq.pop_front();
                    if (t_data !== exp || (pass_sec && !rd_uart)) begin
                        errors++;
                        $display("FAIL tx_data: t_data=%h rd=%b, required %h rd=%b",
                                 t_data, rd_uart, exp, pass_sec);
                    end
                end
            end
            rx_empty = (rxq.size() == 0);
            r_data   = rx_empty ? 8'h00 : rxq[0];
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)",
                     name, act, act, req, req);
        end
    endtask

    task automatic do_reset(input logic [1:0] m);
        @(negedge clock);
        reset_n = 1'b0;
        mode = m;
        en = 1'b0;
        tx_full = 1'b0;
        hold_wr = 1'b0;
        release_on_term = 1'b0;
        pass_sec = 1'b0;
        rxq.delete();
        sbq.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        pops = 0;
        wrs = 0;
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int k;
        k = 0;
        while ((rxq.size() != 0 || sbq.size() != 0) && k < maxc) begin
            @(negedge clock);
            k++;
        end
        repeat (3) @(negedge clock);
        checks++;
        if (k >= maxc) begin
            errors++;
            $display("FAIL %s_timeout: rx left %0d, tx left %0d, required 0 0",
                     name, rxq.size(), sbq.size());
        end
    endtask

    // Independent line model: forward, or reversed body with TERM last.
    task automatic send_line(input logic [7:0] s [$], input bit rev);
        int  len;
        int  body;
        bit  term;
        len  = s.size();
        term = (s[len-1] == TERM);
        body = term ? len - 1 : len;
        if (!rev) begin
            foreach (s[i]) sbq.push_back(s[i]);
        end else begin
            for (int i = body - 1; i >= 0; i--) sbq.push_back(s[i]);
            if (term) sbq.push_back(s[len-1]);
        end
        foreach (s[i]) rxq.push_back(s[i]);
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    vec_t vt [12];

    initial begin
        logic [7:0] line [$];
        logic [1:0] cur_mode;
        int k;

        vt[0]  = '{2'd0, 8'h41, 8'h41};
        vt[1]  = '{2'd0, 8'h7A, 8'h7A};
        vt[2]  = '{2'd1, 8'h41, 8'h61};
        vt[3]  = '{2'd1, 8'h7A, 8'h5A};
        vt[4]  = '{2'd1, 8'h31, 8'h31};
        vt[5]  = '{2'd1, 8'h40, 8'h40};
        vt[6]  = '{2'd1, 8'h5B, 8'h5B};
        vt[7]  = '{2'd1, 8'h60, 8'h60};
        vt[8]  = '{2'd1, 8'h7B, 8'h7B};
        vt[9]  = '{2'd1, 8'h5A, 8'h7A};
        vt[10] = '{2'd1, 8'h61, 8'h41};
        vt[11] = '{2'd0, 8'h61, 8'h61};

        repeat (2) @(negedge clock);
        check("reset_outs", int'({rd_uart, wr_uart, t_data, busy, line_ovf}), 0);

        // Mode 0 back-to-back: pulses two cycles apart
        do_reset(2'd0);
        en = 1'b1;
        pass_sec = 1'b1;
        rxq.push_back(8'h41); sbq.push_back(8'h41);
        rxq.push_back(8'h62); sbq.push_back(8'h62);
        wait_drain("pass2", 40);
        check("pass_count", wrs, 2);
        check("pass_gap", wr_gap, 2);
`ifdef ECHO_STATS_EN
        check("rx_count", int'(rx_count), 2);
        check("tx_count", int'(tx_count), 2);
`endif

        // Vector table through PASS, mode switched between characters
        cur_mode = 2'd0;
        for (int i = 0; i < 12; i++) begin
            if (vt[i].mode != cur_mode) begin
                cur_mode = vt[i].mode;
                mode = cur_mode;
                repeat (4) @(negedge clock);
            end
            rxq.push_back(vt[i].din);
            sbq.push_back(vt[i].dout);
            wait_drain("vec", 30);
        end
        check("vec_count", wrs, 14);
        pass_sec = 1'b0;

        // Mode 2: nothing until TERM, then in order; busy drops on last push
        do_reset(2'd2);
        en = 1'b1;
        hold_wr = 1'b1;
        release_on_term = 1'b1;
        line = '{8'h61, 8'h62, TERM};
        send_line(line, 1'b0);
        wait_drain("line", 60);
        check("line_count", wrs, 3);
        check("line_busy1", int'(busy_at[1]), 1);
        check("line_busy3", int'(busy_at[3]), 0);
        check("line_ovf_clr", int'(line_ovf), 0);

        // Mode 3: reversed body, TERM last
        do_reset(2'd3);
        en = 1'b1;
        hold_wr = 1'b1;
        release_on_term = 1'b1;
        line = '{8'h61, 8'h62, 8'h63, TERM};
        send_line(line, 1'b1);
        wait_drain("rev", 60);
        check("rev_count", wrs, 4);

        // Mode 2 overflow: 16 drained, 17th starts a new line
        do_reset(2'd2);
        en = 1'b1;
        line = {};
        for (int i = 0; i < DEPTH; i++) line.push_back(8'h41 + 8'(i));
        send_line(line, 1'b0);
        line = '{8'h51, TERM};
        send_line(line, 1'b0);
        wait_drain("ovf", 200);
        check("ovf_pop15", int'(ovf_at[15]), 0);
        check("ovf_pop16", int'(ovf_at[16]), 1);
        check("ovf_sticky", int'(line_ovf), 1);
        check("ovf_wrs", wrs, 18);

        // Mode 3 overflow: full reverse, no TERM
        do_reset(2'd3);
        en = 1'b1;
        line = {};
        for (int i = 0; i < DEPTH; i++) line.push_back(8'h30 + 8'(i));
        send_line(line, 1'b1);
        wait_drain("revovf", 200);
        check("revovf_wrs", wrs, DEPTH);

        // en=0 holds off popping
        do_reset(2'd2);
        line = '{8'h78, TERM};
        send_line(line, 1'b0);
        repeat (10) @(negedge clock);
        check("en_pause", pops, 0);
        en = 1'b1;
        wait_drain("en", 40);
        check("en_wrs", wrs, 2);

        // tx_full stalls DRAIN, then reset mid-drain drops the rest
        do_reset(2'd2);
        en = 1'b1;
        tx_full = 1'b1;
        hold_wr = 1'b1;
        line = '{8'h61, 8'h62, 8'h63, 8'h64, TERM};
        foreach (line[i]) rxq.push_back(line[i]);
        k = 0;
        while (pops < 5 && k < 60) begin @(negedge clock); k++; end
        check("full_pops", pops, 5);
        repeat (10) @(negedge clock);
        check("full_busy", int'(busy), 1);
        check("full_nowr", wrs, 0);
        sbq.push_back(8'h61);
        sbq.push_back(8'h62);
        hold_wr = 1'b0;
        tx_full = 1'b0;
        k = 0;
        while (wrs < 2 && k < 40) begin @(negedge clock); k++; end
        check("drain_wrs", wrs, 2);
        reset_n = 1'b0;
        hold_wr = 1'b1;
        #1;
        check("rst_outs", int'({rd_uart, wr_uart, t_data, busy, line_ovf}), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        check("rst_nowr", wrs, 2);
        check("rst_busy", int'(busy), 0);
        check("rst_sb", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1);
    end

endmodule
